// File: rtl/symbol_tx_if.sv
// Byte-source and codec-sample handshake bundle for symbol_tx.
//   write_ready      codec can take one sample this cycle
//   write            sample-write strobe to the codec
//   writedata_left   signed 24-bit sample, left channel
//   writedata_right  signed 24-bit sample, right channel
//   byte_in          byte to transmit
//   byte_valid       byte_in is valid
//   byte_ready       transmitter can accept a byte this cycle
//   busy             frame in progress
// The master modport is the environment (byte source plus codec side);
// the slave modport is the transmitter.
interface symbol_tx_if;
  logic        write_ready;
  logic        write;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;

  modport master (
    output write_ready, byte_in, byte_valid,
    input  write, writedata_left, writedata_right, byte_ready, busy
  );

  modport slave (
    input  write_ready, byte_in, byte_valid,
    output write, writedata_left, writedata_right, byte_ready, busy
  );
endinterface

// File: rtl/symbol_tx.sv
// BPSK byte transmitter feeding an audio codec.
// Each accepted byte is sent as a 10-bit frame: start (0), 8 data bits LSB first, stop (1).
// Every bit lasts SAMPLES_PER_BIT codec strobes. The carrier is a square wave with
// HALF_PERIOD strobes per half-cycle; a 0 bit inverts it. Idle frames emit silence (0).
// Ports:
//   CLOCK_50  sole clock, rising edge
//   reset     asynchronous, active-low
//   bus       symbol_tx_if slave modport (codec sample handshake + byte input)
module symbol_tx #(
  parameter int unsigned        SAMPLES_PER_BIT = 48,
  parameter int unsigned        HALF_PERIOD     = 4,
  parameter logic signed [23:0] AMPLITUDE       = 24'sh200000
) (
  input logic        CLOCK_50,
  input logic        reset,
  symbol_tx_if.slave bus
);

  localparam int unsigned SampleW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int unsigned PhaseW  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [SampleW-1:0] LastSample = SampleW'(SAMPLES_PER_BIT - 1);
  localparam logic [PhaseW-1:0]  LastPhase  = PhaseW'(HALF_PERIOD - 1);
  // AMPLITUDE <= 8388607, so the negation always fits in 24 bits.
  localparam logic signed [23:0] NegAmplitude = -AMPLITUDE;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [SampleW-1:0] sample_cnt_q, sample_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [PhaseW-1:0]  phase_q, phase_d;
  logic               sign_neg_q, sign_neg_d;
  logic [7:0]         shift_q, shift_d;
  logic [23:0]        data_q, data_d;

  logic        strobe;
  logic        cur_bit;
  logic        last_sample;
  logic [23:0] sample_val;

  assign strobe      = bus.write_ready;
  assign last_sample = (sample_cnt_q == LastSample);

  always_comb begin
    cur_bit = 1'b0;
    unique case (state_q)
      StIdle:  cur_bit = 1'b0;
      StStart: cur_bit = 1'b0;
      StData:  cur_bit = shift_q[0];
      StStop:  cur_bit = 1'b1;
      default: cur_bit = 1'b0;
    endcase
  end

  // Positive carrier XOR (bit == 0) reduces to sign_neg XOR bit.
  always_comb begin
    if (state_q == StIdle) begin
      sample_val = 24'd0;
    end else if (sign_neg_q ^ cur_bit) begin
      sample_val = AMPLITUDE;
    end else begin
      sample_val = NegAmplitude;
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    phase_d      = phase_q;
    sign_neg_d   = sign_neg_q;
    shift_d      = shift_q;
    data_d       = data_q;

    // Carrier and output register run on every strobe, idle included.
    if (strobe) begin
      data_d = sample_val;
      if (phase_q == LastPhase) begin
        phase_d    = '0;
        sign_neg_d = ~sign_neg_q;
      end else begin
        phase_d = phase_q + PhaseW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.byte_valid) begin
          state_d      = StStart;
          shift_d      = bus.byte_in;
          sample_cnt_d = '0;
          bit_idx_d    = '0;
        end
      end
      StStart, StData, StStop: begin
        if (strobe) begin
          if (!last_sample) begin
            sample_cnt_d = sample_cnt_q + SampleW'(1);
          end else begin
            sample_cnt_d = '0;
            unique case (state_q)
              StStart: state_d = StData;
              StData: begin
                shift_d = shift_q >> 1;
                if (bit_idx_q == 3'd7) begin
                  state_d   = StStop;
                  bit_idx_d = '0;
                end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                end
              end
              StStop:  state_d = StIdle;
              default: state_d = StIdle;
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      phase_q      <= '0;
      sign_neg_q   <= 1'b0;
      shift_q      <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      phase_q      <= phase_d;
      sign_neg_q   <= sign_neg_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
    end
  end

  assign bus.write           = bus.write_ready;
  assign bus.writedata_left  = data_q;
  assign bus.writedata_right = data_q;
  assign bus.byte_ready      = (state_q == StIdle);
  assign bus.busy            = (state_q != StIdle);

endmodule

// File: doc/symbol_tx.md
SYMBOL_TX -- requirements
Module: symbol_tx

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 48, meaning audio samples per transmitted bit (1 kbaud at 48 kHz); SHALL be >= 1.
REQ-002 Parameter HALF_PERIOD, default 4, meaning samples per carrier half-cycle (6 kHz square carrier at 48 kHz); SHALL be >= 1.
REQ-003 Parameter AMPLITUDE, default 24'sh200000, meaning carrier magnitude; SHALL be in 1..8388607.
REQ-004 CLOCK_50  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low (asserted at 0); one clock; reset is asynchronous and active-low.
REQ-006 write_ready  in  1  codec can accept one sample this cycle.
REQ-007 write  out  1  sample-write strobe to codec.
REQ-008 writedata_left  out  24  signed sample, left channel.
REQ-009 writedata_right  out  24  signed sample, right channel.
REQ-010 byte_in  in  8  byte to transmit.
REQ-011 byte_valid  in  1  byte_in valid.
REQ-012 byte_ready  out  1  block can accept a byte this cycle.
REQ-013 busy  out  1  frame in progress.

Function
REQ-014 write SHALL equal write_ready combinationally; one sample consumed per cycle with write_ready=1 ("strobe").
REQ-015 Frame per byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit exactly SAMPLES_PER_BIT strobes.
REQ-016 FSM states IDLE, START, DATA, STOP; IDLE->START on byte_valid&&byte_ready; START->DATA, DATA->DATA (bit index 0..7), DATA->STOP after bit 7, STOP->IDLE, each on the strobe ending the bit's SAMPLES_PER_BIT-th sample.
REQ-017 byte_ready SHALL be 1 only in IDLE; busy = (state != IDLE); byte latched into shift register on acceptance.
REQ-018 byte_valid while not in IDLE SHALL be ignored (no latch, no state change).
REQ-019 Carrier: phase counter 0..HALF_PERIOD-1 and sign bit (reset +); on every strobe in every state counter advances, sign toggles on wrap; no advance without strobe.
REQ-020 Sample value at a strobe: IDLE -> 0; else +AMPLITUDE if (carrier sign positive) XOR (current bit == 0), else -AMPLITUDE (BPSK: bit 0 inverts carrier).
REQ-021 writedata_left and writedata_right SHALL be registered, identical, loaded on each strobe edge with REQ-020 value computed from pre-edge state/counters; held otherwise.
REQ-022 Latency: byte accepted before a strobe -> that strobe's loaded sample is first start-bit sample.
REQ-023 Acceptance and strobe in the same cycle: strobe loads 0 (IDLE value); start-bit samples begin at next strobe.
REQ-024 write_ready low for any number of cycles SHALL freeze all counters, FSM bit timing, and outputs.
REQ-025 After last stop-bit strobe, byte_ready SHALL be 1 in the following cycle; back-to-back bytes need no idle strobes if byte_valid is present before next strobe.
REQ-026 Negation of AMPLITUDE SHALL be 24-bit two's complement without overflow; no other arithmetic on samples.

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) force: state IDLE, writedata_left/right 0, byte_ready 1, busy 0, sample/bit counters 0, carrier counter 0, sign +, shift register 0.
REQ-028 Reset mid-frame SHALL drop the in-flight byte; no partial-frame resume after release.

Verification (SAMPLES_PER_BIT=4, HALF_PERIOD=2, AMPLITUDE=1000, strobe every 4 clocks)
REQ-029 Assert reset -> writedata 0/0, byte_ready 1, busy 0, write follows write_ready.
REQ-030 Right after reset, send 0xA5 before first strobe -> start: -1000,-1000,+1000,+1000; bit0(1): +1000,+1000,-1000,-1000; 40 samples total, then 0; busy high exactly 40 strobes.
REQ-031 Hold write_ready low 100 clocks mid-DATA -> outputs and counters unchanged; sequence resumes with next expected sample.
REQ-032 Pulse byte_valid (0x3C) during busy -> byte_ready 0, not sent; frame 0xA5 bits unchanged.
REQ-033 Assert reset during bit 3 -> outputs 0 same cycle; after release, new byte 0xFF transmits full frame from start bit, carrier sign +.
REQ-034 AMPLITUDE=8388607 -> samples exactly +8388607 / -8388607, never -8388608.
